// File: rtl/apb_pkg.sv
// Shared types and command-layout helpers for the APB requester and its benches.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Command layout: {write, addr, wdata}, wdata in the low bits.
  localparam int CMD_DATA_LSB = 0;

  function automatic int cmd_addr_lsb(input int data_width);
    return CMD_DATA_LSB + data_width;
  endfunction

  function automatic int cmd_wr_bit(input int data_width, input int addr_width);
    return data_width + addr_width;
  endfunction

  function automatic int cmd_width(input int data_width, input int addr_width);
    return data_width + addr_width + 1;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshakes plus the APB bus, as seen by the requester (master)
// and by whatever sits on the far side (slave).
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CMD_WIDTH  = cmd_width(DATA_WIDTH, ADDR_WIDTH)
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CMD_WIDTH-1:0]  cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags the one on which the requester must give up.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  // count_q holds the wait cycles already spent, so the TIMEOUT-th one sees TIMEOUT-1.
  if (TIMEOUT > 0) begin : g_limit
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    assign expire_o = en_i && (count_q == LAST);
  end else begin : g_off
    assign expire_o = 1'b0;
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: one SETUP->ACCESS transfer per accepted command, response on a
// valid/ready port, with a pready wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CMD_WIDTH  = cmd_width(DATA_WIDTH, ADDR_WIDTH),
  parameter int TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         rstn,
  apb_master_if.master bus
);

  localparam int ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);

  apb_state_e            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic timer_en, timer_clr, timer_expire;

  assign timer_en  = (state_q == ST_ACCESS) && !bus.pready;
  assign timer_clr = (state_q == ST_ACCESS) && (bus.pready || timer_expire);

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rstn     (rstn),
    .en_i     (timer_en),
    .clr_i    (timer_clr),
    .expire_o (timer_expire)
  );

  always_comb begin
    // NOTE: every output gets its hold value first so no path through the case can infer a latch.
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          pwrite_d = bus.cmd_data[CMD_WIDTH-1];
          paddr_d  = bus.cmd_data[ADDR_LSB +: ADDR_WIDTH];
          pwdata_d = bus.cmd_data[CMD_DATA_LSB +: DATA_WIDTH];
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // A pready on the last allowed cycle wins over the timeout.
        if (bus.pready || timer_expire) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !bus.pready;
          rsp_rdata_d = (bus.pready && !pwrite_q) ? bus.prdata : '0;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
